// File: rtl/uart_pkt_pkg.sv
// Shared types and helpers for the UART packet parser slice.
package uart_pkt_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    LEN,
    PAYLOAD,
    CHK,
    HOLD
  } state_e;

  function automatic int unsigned len_width(input int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

  function automatic int unsigned addr_width(input int unsigned max_len);
    return (max_len > 1) ? $clog2(max_len) : 1;
  endfunction

endpackage

// File: rtl/uart_pkt_parser_if.sv
// Byte-stream / packet-handshake bundle between UART receiver, parser and command decoder.
interface uart_pkt_parser_if
  import uart_pkt_pkg::*;
#(
  parameter int unsigned MAX_LEN = 16
);
  localparam int unsigned LW = len_width(MAX_LEN);
  localparam int unsigned AW = addr_width(MAX_LEN);

  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          pkt_valid;
  logic          pkt_ack;
  logic [7:0]    pkt_cmd;
  logic [LW-1:0] pkt_len;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          err_chk;
  logic          err_len;
  logic          err_timeout;
  logic          overrun;

  modport master (
    output rx_data, rx_ready, pkt_ack, rd_addr,
    input  pkt_valid, pkt_cmd, pkt_len, rd_data, err_chk, err_len, err_timeout, overrun
  );

  modport slave (
    input  rx_data, rx_ready, pkt_ack, rd_addr,
    output pkt_valid, pkt_cmd, pkt_len, rd_data, err_chk, err_len, err_timeout, overrun
  );
endinterface

// File: rtl/uart_pkt_buffer.sv
// MAX_LEN x 8 payload register file: synchronous write, combinational read.
module uart_pkt_buffer #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/uart_pkt_parser.sv
// Deframes SYNC/CMD/LEN/payload/CHK packets from the UART byte stream.
// Optional inter-byte timeout enabled by defining UART_PKT_TIMEOUT_EN.
module uart_pkt_parser
  import uart_pkt_pkg::*;
#(
  parameter int unsigned MAX_LEN      = 16,
  parameter int unsigned BAUD_RATE    = 9_600,
  parameter int unsigned SYS_CLK_FREQ = 48_000_000,
  parameter int unsigned TIMEOUT_BITS = 30
) (
  input logic             clk,
  input logic             reset,
  uart_pkt_parser_if.slave bus
);
  localparam int unsigned LW             = len_width(MAX_LEN);
  localparam int unsigned AW             = addr_width(MAX_LEN);
  localparam logic [7:0]  MAX_LEN_B      = 8'(MAX_LEN);
  localparam int unsigned TIMEOUT_CYCLES = (SYS_CLK_FREQ / BAUD_RATE) * TIMEOUT_BITS;

  if (MAX_LEN == 0 || MAX_LEN > 255 || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
    $error("uart_pkt_parser: unsupported MAX_LEN or timeout configuration");
  end

  state_e        state_q;
  logic [7:0]    cmd_q, chk_q, pkt_cmd_q;
  logic [LW-1:0] len_q, idx_q, pkt_len_q;
  logic          pkt_valid_q, err_chk_q, err_len_q, err_to_q, overrun_q;
  logic          timeout_hit;
  logic [7:0]    buf_rdata;

`ifdef UART_PKT_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt_q;
  logic          in_frame;

  assign in_frame    = state_q inside {CMD, LEN, PAYLOAD, CHK};
  // A byte arriving in the terminal cycle takes priority over the timeout.
  assign timeout_hit = in_frame && !bus.rx_ready && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset || bus.rx_ready || !in_frame || timeout_hit) to_cnt_q <= '0;
    else                                                   to_cnt_q <= to_cnt_q + 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      chk_q       <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      pkt_valid_q <= 1'b0;
      pkt_cmd_q   <= '0;
      pkt_len_q   <= '0;
      err_chk_q   <= 1'b0;
      err_len_q   <= 1'b0;
      err_to_q    <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      err_chk_q <= 1'b0;
      err_len_q <= 1'b0;
      err_to_q  <= 1'b0;
      overrun_q <= 1'b0;
      if (timeout_hit) begin
        err_to_q <= 1'b1;
        state_q  <= IDLE;
      end else begin
        case (state_q)
          IDLE: if (bus.rx_ready && bus.rx_data == SYNC_BYTE) state_q <= CMD;
          CMD: if (bus.rx_ready) begin
            cmd_q   <= bus.rx_data;
            chk_q   <= bus.rx_data;
            state_q <= LEN;
          end
          LEN: if (bus.rx_ready) begin
            if (bus.rx_data > MAX_LEN_B) begin
              err_len_q <= 1'b1;
              state_q   <= IDLE;
            end else begin
              len_q   <= bus.rx_data[LW-1:0];
              chk_q   <= chk_q ^ bus.rx_data;
              idx_q   <= '0;
              state_q <= (bus.rx_data == 8'h00) ? CHK : PAYLOAD;
            end
          end
          PAYLOAD: if (bus.rx_ready) begin
            chk_q <= chk_q ^ bus.rx_data;
            idx_q <= idx_q + 1'b1;
            if (idx_q == len_q - 1'b1) state_q <= CHK;
          end
          CHK: if (bus.rx_ready) begin
            if (bus.rx_data == chk_q) begin
              pkt_valid_q <= 1'b1;
              pkt_cmd_q   <= cmd_q;
              pkt_len_q   <= len_q;
              state_q     <= HOLD;
            end else begin
              err_chk_q <= 1'b1;
              state_q   <= IDLE;
            end
          end
          HOLD: begin
            // Ack releases the packet; a coincident byte is then treated as in IDLE.
            if (bus.pkt_ack) begin
              pkt_valid_q <= 1'b0;
              state_q     <= (bus.rx_ready && bus.rx_data == SYNC_BYTE) ? CMD : IDLE;
            end else if (bus.rx_ready) begin
              overrun_q <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  uart_pkt_buffer #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk   (clk),
    .we    (state_q == PAYLOAD && bus.rx_ready),
    .waddr (idx_q[AW-1:0]),
    .wdata (bus.rx_data),
    .raddr (bus.rd_addr),
    .rdata (buf_rdata)
  );

  assign bus.rd_data     = (pkt_valid_q && (LW'(bus.rd_addr) < pkt_len_q)) ? buf_rdata : '0;
  assign bus.pkt_valid   = pkt_valid_q;
  assign bus.pkt_cmd     = pkt_cmd_q;
  assign bus.pkt_len     = pkt_len_q;
  assign bus.err_chk     = err_chk_q;
  assign bus.err_len     = err_len_q;
  assign bus.err_timeout = err_to_q;
  assign bus.overrun     = overrun_q;
endmodule
